fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Issues requests to instruction memory,

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants, fetch FSM states and opcode encodings
package pipeline_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall, bubbles carry a NOP
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             load,
    input  logic [PC_W-1:0]  load_pc,
    input  logic [INS_W-1:0] load_instr,
    output logic             valid,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] instr
);
    logic take;
    assign take = load && !flush;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= INS_W'(NOP_INSTR);
        end else if (flush || !stall) begin
            valid <= take;
            pc    <= take ? load_pc : '0;
            instr <= take ? load_instr : INS_W'(NOP_INSTR);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding request, stall skid and branch redirect
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [PC_W-1:0]  branch_target_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [INS_W-1:0] imem_rdata_i,
    output logic             ifid_valid_o,
    output logic [PC_W-1:0]  ifid_pc_o,
    output logic [INS_W-1:0] ifid_instr_o,
    output logic [6:0]       ifid_opcode_o
);
    fetch_state_e state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d, target;
    logic [INS_W-1:0] skid_instr_q, skid_instr_d;
    logic load;
    assign target        = branch_target_i & ~PC_W'(3);
    // gated by reset_n so the request drops the instant reset asserts
    assign imem_req_o    = reset_n && state_q == FETCH;
    assign imem_addr_o   = pc_q;
    assign ifid_opcode_o = ifid_instr_o[6:0];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        pc_d         = flush_i ? target : pc_q;
        req_pc_d     = req_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        load         = 1'b0;
        unique case (state_q)
            FETCH: begin
                state_d = imem_gnt_i ? (flush_i ? DROP : WAIT) : FETCH;
                if (imem_gnt_i && !flush_i) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_W'(4);
                end
            end
            WAIT: begin
                if (flush_i) state_d = imem_rvalid_i ? FETCH : DROP;
                else if (imem_rvalid_i) begin
                    state_d      = stall_i ? HOLD : FETCH;
                    load         = !stall_i;
                    skid_pc_d    = req_pc_q;
                    skid_instr_d = imem_rdata_i;
                end
            end
            HOLD: begin
                state_d = (flush_i || !stall_i) ? FETCH : HOLD;
                load    = !flush_i && !stall_i;
            end
            DROP: state_d = imem_rvalid_i ? FETCH : DROP;
        endcase
    end
    if_id_reg #(.PC_W(PC_W), .INS_W(INS_W)) u_if_id (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall_i),
        .flush      (flush_i),
        .load       (load),
        .load_pc    (state_q == HOLD ? skid_pc_q : req_pc_q),
        .load_instr (state_q == HOLD ? skid_instr_q : imem_rdata_i),
        .valid      (ifid_valid_o),
        .pc         (ifid_pc_o),
        .instr      (ifid_instr_o)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random memory/stall/flush stimulus; expected program-order stream checked by a monitor
module tb_fetch_stage;
    import pipeline_pkg::*;
    localparam int PC_W = 9;
    localparam int INS_W = 32;
    localparam logic [8:0] RST_PC = 9'h1FC;
    typedef struct packed {logic [8:0] pc; logic [31:0] instr;} exp_t;
    logic clk = 1'b0, reset_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [PC_W-1:0] branch_target_i = '0;
    logic [INS_W-1:0] imem_rdata_i = '0;
    logic imem_req_o, ifid_valid_o;
    logic [PC_W-1:0] imem_addr_o, ifid_pc_o;
    logic [INS_W-1:0] ifid_instr_o;
    logic [6:0] ifid_opcode_o;
    int n_tests = 0, n_fail = 0, delivered = 0;
    logic [31:0] mem [128];
    exp_t exp_q[$];
    logic [8:0] tail_pc;
    logic prev_stall = 1'b0, prev_clear = 1'b1;
    logic last_valid = 1'b0;
    logic [8:0] last_pc = '0;
    logic [31:0] last_instr = NOP_INSTR;
    fetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
        .ifid_opcode_o(ifid_opcode_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back({tail_pc, mem[tail_pc[8:2]]});
            tail_pc = tail_pc + 9'd4;
        end
    endtask
    task automatic restart(input logic [8:0] pc);
        exp_q.delete();
        tail_pc = {pc[8:2], 2'b00};
        top_up();
    endtask
    always @(posedge clk) begin
        prev_stall <= stall_i;
        prev_clear <= flush_i || !reset_n;
    end
    always @(negedge clk) begin
        exp_t e;
        if (imem_req_o) check("req_align", 64'(imem_addr_o[1:0]), 64'd0);
        if (!reset_n || prev_clear) begin
            check("clr_valid", 64'(ifid_valid_o), 64'd0);
            check("clr_instr", 64'(ifid_instr_o), 64'(NOP_INSTR));
            check("clr_pc", 64'(ifid_pc_o), 64'd0);
        end else if (prev_stall) begin
            check("hold_valid", 64'(ifid_valid_o), 64'(last_valid));
            check("hold_pc", 64'(ifid_pc_o), 64'(last_pc));
            check("hold_instr", 64'(ifid_instr_o), 64'(last_instr));
        end else if (ifid_valid_o) begin
            if (exp_q.size() == 0) begin
                check("queue_empty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("ifid_pc", 64'(ifid_pc_o), 64'(e.pc));
                check("ifid_instr", 64'(ifid_instr_o), 64'(e.instr));
                check("ifid_opcode", 64'(ifid_opcode_o), 64'(e.instr[6:0]));
                delivered++;
            end
        end else begin
            check("bubble_instr", 64'(ifid_instr_o), 64'(NOP_INSTR));
        end
        last_valid = ifid_valid_o;
        last_pc    = ifid_pc_o;
        last_instr = ifid_instr_o;
    end
    initial begin
        logic [6:0] ops [5];
        logic [31:0] r;
        logic pend;
        logic [8:0] pend_addr;
        int cnt, stall_left, rst_left;
        logic did_rst, did_023;
        ops = '{R_TYPE, I_TYPE, LW, SW, BR};
        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            mem[i] = {r[31:7], ops[int'(r % 5)]};
        end
        pend = 1'b0; pend_addr = '0; cnt = 0; stall_left = 0; rst_left = 0;
        did_rst = 1'b0; did_023 = 1'b0;
        restart(RST_PC);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(imem_req_o), 64'd0);
        check("rst_valid", 64'(ifid_valid_o), 64'd0);
        check("rst_pc", 64'(ifid_pc_o), 64'd0);
        check("rst_instr", 64'(ifid_instr_o), 64'(NOP_INSTR));
        check("rst_opcode", 64'(ifid_opcode_o), 64'h13);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_req", 64'(imem_req_o), 64'd1);
        check("first_addr", 64'(imem_addr_o), 64'(RST_PC));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (reset_n && imem_req_o && imem_gnt_i) begin
                pend = 1'b1;
                pend_addr = imem_addr_o;
                cnt = $urandom_range(1, 3);
            end
            #1;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) begin
                    reset_n = 1'b1;
                    restart(RST_PC);
                end
                continue;
            end
            if (flush_i) restart(branch_target_i);
            flush_i = 1'b0;
            imem_rvalid_i = 1'b0;
            imem_gnt_i = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = mem[pend_addr[8:2]];
                    pend = 1'b0;
                end
            end else begin
                imem_gnt_i = ($urandom % 4) != 0;
            end
            if (stall_left > 0) begin
                stall_left--;
                stall_i = 1'b1;
            end else if ($urandom % 6 == 0) begin
                stall_left = $urandom_range(0, 3);
                stall_i = 1'b1;
            end else begin
                stall_i = 1'b0;
            end
            if ($urandom % 20 == 0) begin
                flush_i = 1'b1;
                branch_target_i = did_023 ? 9'($urandom) : 9'h023;
                did_023 = 1'b1;
            end
            top_up();
            if (!did_rst && cyc >= 1500 && ifid_valid_o && (pend || cyc >= 2200)) begin
                #1 reset_n = 1'b0;
                #1;
                check("async_req", 64'(imem_req_o), 64'd0);
                check("async_valid", 64'(ifid_valid_o), 64'd0);
                check("async_pc", 64'(ifid_pc_o), 64'd0);
                check("async_instr", 64'(ifid_instr_o), 64'(NOP_INSTR));
                did_rst = 1'b1;
                rst_left = 3;
                pend = 1'b0;
                flush_i = 1'b0;
                stall_i = 1'b0;
                stall_left = 0;
                imem_gnt_i = 1'b0;
                imem_rvalid_i = 1'b0;
            end
        end
        check("progress", 64'(delivered >= 100), 64'd1);
        check("mid_reset_done", 64'(did_rst), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
